// File: rtl/result_ram_reader.sv
// Streams the DIM*DIM product matrix out of the registered result RAM over a valid/ready port.
// Build option ROW_ORDER_EN: read in row-major order instead of the RAM's native column-major order.
module result_ram_reader #(
    parameter int unsigned DIM    = 8,
    parameter int unsigned DATA_W = 19,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     N       = DIM * DIM;
    localparam logic [ADDR_W:0] LAST_RD = (ADDR_W + 1)'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              issue;
    logic              push;
    logic              pop;

    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight_last;

    logic [DATA_W-1:0] fifo_data  [2];
    logic [ADDR_W-1:0] fifo_index [2];
    logic              fifo_last  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic [2:0]        occupancy;
    logic [2:0]        issue_limit;

`ifdef ROW_ORDER_EN
    localparam logic [ADDR_W:0] DIM_W = (ADDR_W + 1)'(DIM);
    assign rd_addr = ADDR_W'(DIM_W * (rd_cnt % DIM_W) + rd_cnt / DIM_W);
`else
    assign rd_addr = rd_cnt[ADDR_W-1:0];
`endif

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Issue rule "count + inflight - pop < DEPTH" rearranged to avoid underflow.
    assign occupancy   = {1'b0, count} + {2'b00, inflight};
    assign issue_limit = 3'(DEPTH) + {2'b00, pop};

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                issue = (occupancy < issue_limit);
                if (issue && (rd_cnt == LAST_RD)) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last[rd_ptr]) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            inflight_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + (ADDR_W + 1)'(1);
            end
            inflight      <= issue;
            inflight_addr <= rd_addr;
            inflight_last <= (rd_cnt == LAST_RD);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_index[i] <= '0;
                fifo_last[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr]  <= ram_rdata;
                fifo_index[wr_ptr] <= inflight_addr;
                fifo_last[wr_ptr]  <= inflight_last;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign ram_rd_en = issue;
    assign ram_addr  = issue ? rd_addr : '0;

    assign out_data  = out_valid ? fifo_data[rd_ptr]  : '0;
    assign out_index = out_valid ? fifo_index[rd_ptr] : '0;
    assign out_last  = out_valid ? fifo_last[rd_ptr]  : 1'b0;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_result_ram_reader.sv
// Directed bench for result_ram_reader with a registered RAM model holding mem[a] = a-32.
// Define ROW_ORDER_EN for both bench and RTL to exercise the row-major build.
module tb_result_ram_reader;

    localparam int DIM    = 8;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 6;
    localparam int N      = DIM * DIM;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mem [N];

    result_ram_reader #(
        .DIM   (DIM),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ram_rd_en(ram_rd_en),
        .ram_addr (ram_addr),
        .ram_rdata(ram_rdata),
        .out_data (out_data),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_index(input int k);
`ifdef ROW_ORDER_EN
        return DIM * (k % DIM) + k / DIM;
`else
        return k;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, ram_rd_en, 0);
        chk({tag, "_addr"},  ram_addr,  0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data,  0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_last"},  out_last,  0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
    endtask

    // Cycle 0 is the cycle in which start is raised; mode 0 ready=1, 1 toggling,
    // 2 ready held low until cycle 23, 3 ready=1 with a stray start at word 10.
    task automatic unload(input int mode, output int n_xfer, output int n_done,
                          output int first_v, output int done_c);
        int                k       = 0;
        int                issued  = 0;
        logic              stalled = 1'b0;
        logic              pulsed  = 1'b0;
        logic [DATA_W-1:0] s_data  = '0;
        logic [ADDR_W-1:0] s_idx   = '0;
        logic              s_last  = 1'b0;
        logic [DATA_W-1:0] ed;
        n_done  = 0;
        first_v = -1;
        done_c  = -1;
        n_xfer  = 0;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode == 3 && k == 10 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            case (mode)
                1:       out_ready = (cyc % 2 == 1);
                2:       out_ready = (cyc >= 23);
                default: out_ready = 1'b1;
            endcase
            #1;
            if (cyc == 1) begin
                chk("first_rd_en", ram_rd_en, 1);
                chk("first_addr",  ram_addr,  exp_index(0));
                chk("busy_run",    busy,      1);
            end
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_index", out_index, s_idx);
                chk("hold_data",  out_data,  s_data);
                chk("hold_last",  out_last,  s_last);
            end
            if (mode == 2 && cyc == 22) begin
                chk("stall_rd_en", ram_rd_en, 0);
                chk("stall_index", out_index, exp_index(0));
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (ram_rd_en) issued++;
            if (out_valid && out_ready) begin
                ed = DATA_W'(exp_index(k) - 32);
                chk("index", out_index, exp_index(k));
                chk("data",  out_data,  ed);
                chk("last",  out_last,  (k == N - 1));
                k++;
            end
            chk("buffered_le_2", (issued - k <= 2), 1);
            stalled = out_valid && !out_ready;
            s_data  = out_data;
            s_idx   = out_index;
            s_last  = out_last;
            if (done) begin
                n_done++;
                done_c = cyc;
                chk("done_after_last", k, N);
            end
            if (done_c >= 0 && cyc == done_c + 1) begin
                chk("busy_after_done", busy, 0);
                chk("done_pulse_1cyc", done, 0);
                n_xfer = k;
                return;
            end
        end
        n_xfer = k;
        chk("unload_timeout", n_done, 1);
    endtask

    initial begin
        int n_xfer, n_done, first_v, done_c, k;
        for (int a = 0; a < N; a++) mem[a] = DATA_W'(a - 32);
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        unload(0, n_xfer, n_done, first_v, done_c);
        chk("t1_first_valid", first_v, 3);
        chk("t1_done_cycle",  done_c,  67);
        chk("t1_xfers",       n_xfer,  N);
        chk("t1_dones",       n_done,  1);

        unload(1, n_xfer, n_done, first_v, done_c);
        chk("t2_xfers", n_xfer, N);
        chk("t2_dones", n_done, 1);

        unload(2, n_xfer, n_done, first_v, done_c);
        chk("t3_first_valid", first_v, 3);
        chk("t3_xfers",       n_xfer,  N);
        chk("t3_dones",       n_done,  1);

        unload(3, n_xfer, n_done, first_v, done_c);
        chk("t4_xfers", n_xfer, N);
        chk("t4_dones", n_done, 1);
        unload(0, n_xfer, n_done, first_v, done_c);
        chk("t4_replay_first_valid", first_v, 3);
        chk("t4_replay_xfers",       n_xfer,  N);

        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        k         = 0;
        for (int cyc = 1; cyc <= 200 && k < 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                chk("t5_index", out_index, exp_index(k));
                k++;
            end
        end
        chk("t5_reached_word30", k, 30);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("t5_after_reset");
        @(negedge clk);
        #1;
        chk("t5_idle_valid", out_valid, 0);
        chk("t5_idle_busy",  busy,      0);
        unload(0, n_xfer, n_done, first_v, done_c);
        chk("t5_restart_first_valid", first_v, 3);
        chk("t5_restart_xfers",       n_xfer,  N);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
